// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the 2-way cache sequencer: state encoding,
// line geometry and the beat-to-byte-offset mapping.
package cache_ctrl_pkg;

    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int OFS_W   = 3;

    localparam int BEAT_W    = $clog2(WORDS);
    localparam int FILL_W    = $clog2(WORDS + MEM_LAT);
    localparam int FILL_LAST = WORDS + MEM_LAT - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WB    = 2'd1,
        ST_FILL  = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    // Words are 16-bit, so beat k sits at byte offset 2*k.
    function automatic logic [OFS_W-1:0] beat_ofs(input logic [OFS_W-1:0] k);
        return {k[OFS_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/victim_select.sv
// Replacement choice for a 2-way set: fill an invalid way first,
// otherwise evict the way that is not most recently used.
module victim_select (
    input  logic valid0,
    input  logic valid1,
    input  logic dirty0,
    input  logic dirty1,
    input  logic lru_mru,
    output logic victim,
    output logic victim_dirty
);

    always_comb begin
        if (!valid0)
            victim = 1'b0;
        else if (!valid1)
            victim = 1'b1;
        else
            victim = ~lru_mru;
        // An invalid line never needs writing back, whatever its dirty bit says.
        victim_dirty = victim ? (valid1 & dirty1) : (valid0 & dirty0);
    end

endmodule

// File: rtl/cache2way_ctrl.sv
// Sequencer for a 2-way, 256-set cache: hit handling in IDLE, and on a miss
// write-back of a dirty victim, line refill, final access and LRU update.
module cache2way_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             lru_mru,
    output logic [1:0]       way_en,
    output logic             cache_comp,
    output logic             cache_write,
    output logic             cache_valid_in,
    output logic [OFS_W-1:0] cache_ofs,
    output logic             fill_sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [OFS_W-1:0] mem_ofs,
    output logic             mem_tag_sel,
    output logic             lru_write,
    output logic             lru_data,
    output logic             stall,
    output logic             done,
    output logic             cache_hit,
    output logic             err
);

    state_t              r_state;
    state_t              w_state_next;
    logic [BEAT_W-1:0]   r_wb_cnt;
    logic [FILL_W-1:0]   r_iss_cnt;
    logic [BEAT_W-1:0]   r_ret_cnt;
    logic                r_victim;
    logic                r_is_wr;

    logic                w_victim;
    logic                w_victim_dirty;
    logic                w_hit0;
    logic                w_hit1;
    logic                w_miss;
    logic [1:0]          w_victim_en;

    victim_select u_victim_select (
        .valid0       (valid0),
        .valid1       (valid1),
        .dirty0       (dirty0),
        .dirty1       (dirty1),
        .lru_mru      (lru_mru),
        .victim       (w_victim),
        .victim_dirty (w_victim_dirty)
    );

    assign w_hit0      = hit0 & valid0;
    assign w_hit1      = hit1 & valid1;
    assign w_victim_en = r_victim ? 2'b10 : 2'b01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Beat counters and the request context latched at the miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_cnt  <= '0;
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_victim  <= 1'b0;
            r_is_wr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wb_cnt  <= '0;
                    r_iss_cnt <= '0;
                    r_ret_cnt <= '0;
                    if (w_miss) begin
                        r_victim <= w_victim;
                        r_is_wr  <= req_wr;
                    end
                end
                ST_WB: r_wb_cnt <= r_wb_cnt + 1'b1;
                ST_FILL: begin
                    r_iss_cnt <= r_iss_cnt + 1'b1;
                    if (r_iss_cnt >= FILL_W'(MEM_LAT))
                        r_ret_cnt <= r_ret_cnt + 1'b1;
                end
                default: begin
                    r_wb_cnt  <= '0;
                    r_iss_cnt <= '0;
                    r_ret_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_miss         = 1'b0;
        way_en         = 2'b00;
        cache_comp     = 1'b0;
        cache_write    = 1'b0;
        cache_valid_in = 1'b0;
        cache_ofs      = '0;
        fill_sel       = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_ofs        = '0;
        mem_tag_sel    = 1'b0;
        lru_write      = 1'b0;
        lru_data       = 1'b0;
        stall          = 1'b0;
        done           = 1'b0;
        cache_hit      = 1'b0;
        err            = 1'b0;

        // Outputs stay quiet for the whole time reset is held.
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (req_rd && req_wr) begin
                        err = 1'b1;
                    end else if (req_rd || req_wr) begin
                        cache_comp  = 1'b1;
                        way_en      = 2'b11;
                        cache_write = req_wr;
                        if (w_hit0 && w_hit1) begin
                            err  = 1'b1;
                            done = 1'b1;
                        end else if (w_hit0 || w_hit1) begin
                            done      = 1'b1;
                            cache_hit = 1'b1;
                            lru_write = 1'b1;
                            lru_data  = w_hit1;
                        end else begin
                            w_miss       = 1'b1;
                            w_state_next = w_victim_dirty ? ST_WB : ST_FILL;
                        end
                    end
                end
                ST_WB: begin
                    stall       = 1'b1;
                    way_en      = w_victim_en;
                    cache_ofs   = beat_ofs(OFS_W'(r_wb_cnt));
                    mem_wr      = 1'b1;
                    mem_ofs     = beat_ofs(OFS_W'(r_wb_cnt));
                    mem_tag_sel = 1'b1;
                    if (r_wb_cnt == BEAT_W'(WORDS - 1))
                        w_state_next = ST_FILL;
                end
                ST_FILL: begin
                    stall = 1'b1;
                    if (r_iss_cnt < FILL_W'(WORDS)) begin
                        mem_rd  = 1'b1;
                        mem_ofs = beat_ofs(OFS_W'(r_iss_cnt));
                    end
                    // Data issued MEM_LAT cycles ago is arriving now.
                    if (r_iss_cnt >= FILL_W'(MEM_LAT)) begin
                        cache_write    = 1'b1;
                        way_en         = w_victim_en;
                        fill_sel       = 1'b1;
                        cache_valid_in = 1'b1;
                        cache_ofs      = beat_ofs(OFS_W'(r_ret_cnt));
                    end
                    if (r_iss_cnt == FILL_W'(FILL_LAST))
                        w_state_next = ST_FINAL;
                end
                ST_FINAL: begin
                    cache_comp   = 1'b1;
                    way_en       = w_victim_en;
                    cache_write  = r_is_wr;
                    done         = 1'b1;
                    lru_write    = 1'b1;
                    lru_data     = r_victim;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    err          = 1'b1;
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache2way_ctrl.sv
// Random and directed transactions against a timeline model of the
// cache sequencer; every cycle's output bundle is compared.
module tb_cache2way_ctrl;
    import cache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic req_rd, req_wr, hit0, hit1, valid0, valid1, dirty0, dirty1, lru_mru;
    logic [1:0]       way_en;
    logic             cache_comp, cache_write, cache_valid_in, fill_sel;
    logic [OFS_W-1:0] cache_ofs, mem_ofs;
    logic             mem_rd, mem_wr, mem_tag_sel, lru_write, lru_data;
    logic             stall, done, cache_hit, err;

    typedef struct packed {
        logic [1:0] way_en;
        logic       comp;
        logic       cwr;
        logic       vin;
        logic [2:0] cofs;
        logic       fsel;
        logic       mrd;
        logic       mwr;
        logic [2:0] mofs;
        logic       tsel;
        logic       lwr;
        logic       ldata;
        logic       stall;
        logic       done;
        logic       hit;
        logic       err;
    } outs_t;

    outs_t obs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache2way_ctrl dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru_mru(lru_mru),
        .way_en(way_en), .cache_comp(cache_comp), .cache_write(cache_write),
        .cache_valid_in(cache_valid_in), .cache_ofs(cache_ofs), .fill_sel(fill_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ofs(mem_ofs), .mem_tag_sel(mem_tag_sel),
        .lru_write(lru_write), .lru_data(lru_data), .stall(stall), .done(done),
        .cache_hit(cache_hit), .err(err)
    );

    assign obs = {way_en, cache_comp, cache_write, cache_valid_in, cache_ofs, fill_sel,
                  mem_rd, mem_wr, mem_ofs, mem_tag_sel, lru_write, lru_data,
                  stall, done, cache_hit, err};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check_eq(tag, 32'(obs), 32'(outs_t'('0)));
        @(posedge clk);
        #1;
    endtask

    // Model: classify the request, then walk the expected timeline cycle by cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic h0, input logic h1,
                           input logic v0, input logic v1, input logic d0, input logic d1,
                           input logic lru);
        logic  eh0, eh1, vic, vdirty, miss;
        int    fill_start, last;
        outs_t e;
        req_rd = rd; req_wr = wr; hit0 = h0; hit1 = h1;
        valid0 = v0; valid1 = v1; dirty0 = d0; dirty1 = d1; lru_mru = lru;
        eh0 = h0 & v0;
        eh1 = h1 & v1;
        if (v0 && v1) vic = !lru;
        else          vic = v0;
        vdirty     = vic ? (v1 & d1) : (v0 & d0);
        miss       = (rd ^ wr) && !eh0 && !eh1;
        fill_start = 1 + (vdirty ? WORDS : 0);
        last       = miss ? fill_start + WORDS + MEM_LAT : 0;
        $display("txn rd=%0b wr=%0b h=%0b%0b v=%0b%0b d=%0b%0b lru=%0b miss=%0b victim=%0d cycles=%0d",
                 rd, wr, h1, h0, v1, v0, d1, d0, lru, miss, vic, last + 1);
        for (int t = 0; t <= last; t++) begin
            e = '0;
            if (t == 0) begin
                if (rd && wr) begin
                    e.err = 1'b1;
                end else if (rd || wr) begin
                    e.comp = 1'b1; e.way_en = 2'b11; e.cwr = wr;
                    if (eh0 && eh1) begin
                        e.err = 1'b1; e.done = 1'b1;
                    end else if (eh0 || eh1) begin
                        e.done = 1'b1; e.hit = 1'b1; e.lwr = 1'b1; e.ldata = eh1;
                    end
                end
            end else if (t < fill_start) begin
                e.stall = 1'b1; e.way_en = vic ? 2'b10 : 2'b01;
                e.cofs = 3'(2 * (t - 1)); e.mwr = 1'b1; e.mofs = 3'(2 * (t - 1)); e.tsel = 1'b1;
            end else if (t < last) begin
                e.stall = 1'b1;
                if (t - fill_start < WORDS) begin
                    e.mrd = 1'b1; e.mofs = 3'(2 * (t - fill_start));
                end
                if (t - fill_start >= MEM_LAT) begin
                    e.cwr = 1'b1; e.fsel = 1'b1; e.vin = 1'b1;
                    e.way_en = vic ? 2'b10 : 2'b01;
                    e.cofs = 3'(2 * (t - fill_start - MEM_LAT));
                end
            end else begin
                e.comp = 1'b1; e.way_en = vic ? 2'b10 : 2'b01; e.cwr = wr;
                e.done = 1'b1; e.lwr = 1'b1; e.ldata = vic;
            end
            @(negedge clk);
            check_eq($sformatf("out t=%0d", t), 32'(obs), 32'(e));
            @(posedge clk);
            #1;
        end
        req_rd = 1'b0; req_wr = 1'b0;
        idle_check("idle_after");
    endtask

    initial begin
        rst = 1'b1;
        {req_rd, req_wr, hit0, hit1, valid0, valid1, dirty0, dirty1, lru_mru} = '0;
        #1;
        req_rd = 1'b1; hit0 = 1'b1; valid0 = 1'b1;
        @(negedge clk);
        check_eq("reset_quiet", 32'(obs), 32'(outs_t'('0)));
        req_rd = 1'b0; hit0 = 1'b0; valid0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check("reset_idle");

        // rd wr h0 h1 v0 v1 d0 d1 lru
        run_txn(1, 0, 0, 1, 1, 1, 0, 0, 0);
        run_txn(1, 0, 0, 0, 1, 1, 0, 0, 0);
        run_txn(0, 1, 0, 0, 1, 1, 1, 0, 1);
        run_txn(1, 0, 0, 0, 0, 1, 1, 1, 0);
        run_txn(1, 0, 1, 1, 1, 1, 0, 0, 0);
        run_txn(1, 1, 1, 0, 1, 1, 0, 0, 0);

        // Dirty miss interrupted by reset during the third write-back beat.
        req_rd = 1'b1; valid0 = 1'b1; valid1 = 1'b1; dirty0 = 1'b1; lru_mru = 1'b1;
        hit0 = 1'b0; hit1 = 1'b0;
        $display("txn reset during write-back");
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_eq("wb3_strobe", 32'({mem_wr, mem_ofs}), 32'({1'b1, 3'd4}));
        #1;
        rst = 1'b1; req_rd = 1'b0;
        #1;
        check_eq("rst_async", 32'(obs), 32'(outs_t'('0)));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check("rst_then_idle");
        run_txn(1, 0, 0, 1, 1, 1, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic rd, wr, h0, h1, v0, v1, d0, d1, lru;
            int kind;
            kind = $urandom_range(0, 9);
            {v0, v1, d0, d1, lru} = 5'($urandom);
            h0 = 1'b0; h1 = 1'b0;
            rd = $urandom_range(0, 1);
            wr = !rd;
            case (kind)
                0, 1: begin h0 = 1'b1; v0 = 1'b1; end
                2, 3: begin h1 = 1'b1; v1 = 1'b1; end
                4:    begin h0 = 1'b1; h1 = 1'b1; v0 = 1'b1; v1 = 1'b1; end
                5:    begin rd = 1'b1; wr = 1'b1; end
                default: begin h0 = !v0 & 1'($urandom); h1 = !v1 & 1'($urandom); end
            endcase
            run_txn(rd, wr, h0, h1, v0, v1, d0, d1, lru);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache2way_ctrl.md
Name:
cache2way_ctrl

Overview:
- Sequencing FSM for the 2-way set-associative, 256-set data cache.
- Each cycle it drives the two way arrays, the 1-bit-per-set LRU store and the 4-banked main memory.
- On a CPU read/write it checks both ways and chooses a victim from the valid bits and the LRU bit.
- On a miss it writes back a dirty victim, refills the line, performs the final access, then updates the LRU bit.

Parameters:
- WORDS, 4, words per line; power of 2; byte offset = 2*word index.
- MEM_LAT, 2, cycles from mem_rd issue to mem_data valid (fixed, ≥1).
- OFS_W, 3, byte-offset width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_rd  in  1  CPU read request; held stable while stall=1
- req_wr  in  1  CPU write request; held stable while stall=1
- hit0, hit1  in  1 each  way tag-compare result (valid only while cache_comp=1)
- valid0, valid1  in  1 each  way valid bit for the indexed set
- dirty0, dirty1  in  1 each  way dirty bit for the indexed set
- lru_mru  in  1  LRU store output: most recently used way of the indexed set
- way_en  out  2  one-hot way enable to the cache arrays
- cache_comp  out  1  compare mode (tag check, write sets dirty)
- cache_write  out  1  array write strobe
- cache_valid_in  out  1  valid bit written on fill
- cache_ofs  out  OFS_W  array word offset
- fill_sel  out  1  1 = array write data from mem_data, 0 = from CPU
- mem_rd, mem_wr  out  1 each  memory strobes
- mem_ofs  out  OFS_W  memory word offset
- mem_tag_sel  out  1  1 = memory address uses the victim tag, 0 = the request tag
- lru_write  out  1  LRU store write enable
- lru_data  out  1  way written as the new MRU
- stall  out  1  busy; CPU must hold its request
- done  out  1  one-cycle completion pulse
- cache_hit  out  1  qualifies done: access hit
- err  out  1  protocol/consistency error

Behaviour:
- Reset: state IDLE, counters 0. Every output is 0 from reset assertion until the first post-reset request.
- Reset mid-operation: return to IDLE immediately and abandon in-flight memory beats. No LRU write, no done.

IDLE:
- req_rd|req_wr drives cache_comp=1, way_en=2'b11, cache_write=req_wr, fill_sel=0. stall=0.
- Hit in way w (hitw&validw): in the same cycle drive done=1, cache_hit=1, lru_write=1, lru_data=w. Stay in IDLE.
- Miss: latch the victim and the request type. Go to WB if the victim is valid and dirty, otherwise to FILL. stall=1 from the next cycle.
- Victim choice: way0 if !valid0; else way1 if !valid1; else ~lru_mru.
- hit0&valid0&hit1&valid1: err=1, done=1, cache_hit=0, no state change.
- req_rd&req_wr: err=1, no access.

WB (WORDS cycles, k=0..WORDS-1):
- Drive cache_comp=0, way_en=victim, cache_write=0, cache_ofs=2k.
- Drive mem_wr=1, mem_ofs=2k, mem_tag_sel=1.
- After the last beat go to FILL.

FILL (WORDS+MEM_LAT cycles, i=0..WORDS+MEM_LAT-1):
- Issue: mem_rd=1, mem_ofs=2i while i<WORDS. mem_tag_sel=0.
- Write-back of returned data: while i≥MEM_LAT, drive cache_write=1, way_en=victim, fill_sel=1, cache_valid_in=1, cache_ofs=2(i-MEM_LAT).
- Issue and write-back overlap, using separate issue and return counters.

FINAL (1 cycle):
- Drive cache_comp=1, way_en=victim, cache_write=latched write, fill_sel=0.
- Drive done=1, cache_hit=0, lru_write=1, lru_data=victim, stall=0. Then go to IDLE.
- A write allocate sets dirty through the comp write.

Latency with MEM_LAT=2, request in cycle T0:
- Hit: done in T0.
- Clean miss: done in T7.
- Dirty miss: done in T11.

Other rules:
- Requests arriving while stall=1 are ignored.
- Counters wrap modulo WORDS. An out-of-range state forces IDLE and sets err=1.

Decomposition:
- Package cache_ctrl_pkg holds:
  - the state encoding (IDLE, WB, FILL, FINAL);
  - WORDS, MEM_LAT, OFS_W;
  - the beat-to-offset function (2*k).
- Sub-module victim_select (combinational): valid0, valid1, dirty0, dirty1, lru_mru → victim, victim_dirty. It is reused by future replacement-policy variants.

Test Plan:
- Read hit way1 (hit1=valid1=1, hit0=0) at T0 → done=cache_hit=1 in T0, lru_write=1, lru_data=1, stall=0.
- Read miss, both ways valid and clean, lru_mru=0 → victim way1:
  - mem_rd at mem_ofs 0,2,4,6 in T1–T4;
  - cache_write at cache_ofs 0,2,4,6 in T3–T6 with way_en=2'b10;
  - done=1, cache_hit=0, lru_data=1 in T7.
- Write miss, lru_mru=1, way0 valid and dirty → mem_wr with mem_tag_sel=1 at mem_ofs 0,2,4,6 in T1–T4, fill in T5–T10, FINAL cache_write=1 with cache_comp=1 in T11, done=1.
- Miss with valid0=0 and valid1=1, lru_mru=0 → way0 chosen (way_en=2'b01) and no WB.
- Assert rst during the third WB beat → next cycle all outputs are 0 and state is IDLE; a following read hit completes in 1 cycle.
- Both ways hit, or req_rd=req_wr=1 → err=1 that cycle, no mem strobes, no LRU write.
